// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - forwarding select codes, zero-register constant and pipeline stage record
package fwd_pkg;

    localparam int FWD_REG_AW = 5;

    localparam logic [1:0] FWD_QB  = 2'b00;
    localparam logic [1:0] FWD_EXR = 2'b01;
    localparam logic [1:0] FWD_MR  = 2'b10;
    localparam logic [1:0] FWD_MDO = 2'b11;

    localparam logic [FWD_REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [FWD_REG_AW-1:0] rn;
        logic                  wreg;
        logic                  m2reg;
    } stage_t;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-operand forwarding select and load-use match
module fwd_sel
    import fwd_pkg::*;
(
    input  logic                  use_i,
    input  logic [FWD_REG_AW-1:0] src_i,
    input  stage_t                e_i,
    input  stage_t                m_i,
    output logic [1:0]            sel_o,
    output logic                  haz_o
);

    logic e_hit;
    logic m_hit;

    assign e_hit = use_i && e_i.wreg && (e_i.rn != REG_ZERO) && (e_i.rn == src_i);
    assign m_hit = use_i && m_i.wreg && (m_i.rn != REG_ZERO) && (m_i.rn == src_i);

    // EX wins over MEM; a load still in EX has no data yet, so it only raises a hazard
    always_comb begin
        sel_o = FWD_QB;
        if (e_hit && !e_i.m2reg) begin
            sel_o = FWD_EXR;
        end else if (m_hit) begin
            sel_o = m_i.m2reg ? FWD_MDO : FWD_MR;
        end
    end

    assign haz_o = e_hit && e_i.m2reg;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - ID-stage forwarding/load-use controller; optional FWD_STATS_EN counters
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW = FWD_REG_AW
`ifdef FWD_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [REG_AW-1:0] d_rn,
    input  logic              d_wreg,
    input  logic              d_m2reg,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic              flush,
    input  logic              hold,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic              wpcir,
    output logic              bubble
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  fwd_cnt
`endif
);

    stage_t e_q;
    stage_t m_q;
    stage_t e_d;
    logic   haz_a;
    logic   haz_b;
    logic   stall;

    fwd_sel u_sel_a (
        .use_i (d_use_rs),
        .src_i (d_rs),
        .e_i   (e_q),
        .m_i   (m_q),
        .sel_o (fwda),
        .haz_o (haz_a)
    );

    fwd_sel u_sel_b (
        .use_i (d_use_rt),
        .src_i (d_rt),
        .e_i   (e_q),
        .m_i   (m_q),
        .sel_o (fwdb),
        .haz_o (haz_b)
    );

    // a flushed or empty ID slot never stalls; flush overrides a pending load-use
    assign stall  = d_valid && !flush && (haz_a || haz_b);
    assign wpcir  = !stall;
    assign bubble = stall || flush || !d_valid;

    // next EX record: a bubble enters as an all-zero non-writing NOP
    always_comb begin
        e_d = '0;
        if (!bubble) begin
            e_d.rn    = d_rn;
            e_d.wreg  = d_wreg;
            e_d.m2reg = d_m2reg;
        end
    end

    // shadow the EX/MEM destination state; hold freezes the whole pipeline
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            e_q <= '0;
            m_q <= '0;
        end else if (!hold) begin
            m_q <= e_q;
            e_q <= e_d;
        end
    end

`ifdef FWD_STATS_EN
    logic fwd_any;
    assign fwd_any = (fwda != FWD_QB) || (fwdb != FWD_QB);

    // saturating event counters, advanced only on non-frozen edges
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!hold) begin
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (fwd_any && !(&fwd_cnt)) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - scoreboard bench for fwd_hazard_ctrl with directed vectors
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       clrn;
    logic       d_valid;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [4:0] d_rn;
    logic       d_wreg;
    logic       d_m2reg;
    logic       d_use_rs;
    logic       d_use_rt;
    logic       flush;
    logic       hold;
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       wpcir;
    logic       bubble;
`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] fwd_cnt;
`endif

    fwd_hazard_ctrl dut (
        .clk      (clk),
        .clrn     (clrn),
        .d_valid  (d_valid),
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_rn     (d_rn),
        .d_wreg   (d_wreg),
        .d_m2reg  (d_m2reg),
        .d_use_rs (d_use_rs),
        .d_use_rt (d_use_rt),
        .flush    (flush),
        .hold     (hold),
        .fwda     (fwda),
        .fwdb     (fwdb),
        .wpcir    (wpcir),
        .bubble   (bubble)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .fwd_cnt  (fwd_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic [5:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: one expectation per cycle, checked on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [5:0] got;
            e   = exp_q.pop_front();
            got = {fwda, fwdb, wpcir, bubble};
            n_tests++;
            if (got !== e.v) begin
                n_fail++;
                $display("FAIL %s: got fwda=%b fwdb=%b wpcir=%b bubble=%b, expected fwda=%b fwdb=%b wpcir=%b bubble=%b",
                         e.name, got[5:4], got[3:2], got[1], got[0], e.v[5:4], e.v[3:2], e.v[1], e.v[0]);
            end
        end
    end

    task automatic apply(input string nm, input logic rstn, input logic v,
                         input int rs, input int rt, input int rn,
                         input logic wr, input logic m2, input logic urs, input logic urt,
                         input logic fl, input logic hd,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic wp, input logic bb);
        exp_t e;
        clrn     = rstn;
        d_valid  = v;
        d_rs     = 5'(rs);
        d_rt     = 5'(rt);
        d_rn     = 5'(rn);
        d_wreg   = wr;
        d_m2reg  = m2;
        d_use_rs = urs;
        d_use_rt = urt;
        flush    = fl;
        hold     = hd;
        e.name   = nm;
        e.v      = {fa, fb, wp, bb};
        exp_q.push_back(e);
    endtask

    task automatic drv(input string nm, input logic rstn, input logic v,
                       input int rs, input int rt, input int rn,
                       input logic wr, input logic m2, input logic urs, input logic urt,
                       input logic fl, input logic hd,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic wp, input logic bb);
        @(posedge clk);
        #1;
        apply(nm, rstn, v, rs, rt, rn, wr, m2, urs, urt, fl, hd, fa, fb, wp, bb);
    endtask

    initial begin
        int guard;
        //          name           rstn v  rs rt rn wr m2 urs urt fl hd  fa     fb     wp bb
        apply("reset",          0,   1, 1, 2, 0, 0, 0, 1,  1,  0, 0, 2'b00, 2'b00, 1, 0);
        @(negedge clk);
        // EX ALU forward
        drv("t1_add",           1,   1, 1, 2, 3, 1, 0, 1,  1,  0, 0, 2'b00, 2'b00, 1, 0);
        drv("t1_sub_fwdb_ex",   1,   1, 4, 3, 6, 1, 0, 1,  1,  0, 0, 2'b00, 2'b01, 1, 0);
        // load-use: one stall, then MEM load data
        drv("t2_lw",            1,   1, 7, 8, 4, 1, 1, 1,  0,  0, 0, 2'b00, 2'b00, 1, 0);
        drv("t2_stall",         1,   1, 4, 9, 10,1, 0, 1,  1,  0, 0, 2'b00, 2'b00, 0, 1);
        drv("t2_after_mdo",     1,   1, 4, 9, 10,1, 0, 1,  1,  0, 0, 2'b11, 2'b00, 1, 0);
        // EX priority over MEM, then MEM ALU after a bubble
        drv("t3_w5_a",          1,   1, 0, 0, 5, 1, 0, 0,  0,  0, 0, 2'b00, 2'b00, 1, 0);
        drv("t3_w5_b_mr",       1,   1, 10,0, 5, 1, 0, 1,  0,  0, 0, 2'b10, 2'b00, 1, 0);
        drv("t3_ex_prio",       1,   0, 5, 5, 0, 0, 0, 1,  0,  0, 0, 2'b01, 2'b00, 1, 1);
        drv("t3_mem_alu",       1,   1, 5, 5, 12,1, 0, 1,  1,  0, 0, 2'b10, 2'b10, 1, 0);
        // register zero never forwards or stalls
        drv("t4_lw_r0",         1,   1, 1, 2, 0, 1, 1, 0,  0,  0, 0, 2'b00, 2'b00, 1, 0);
        drv("t4_read_r0_e",     1,   1, 0, 0, 13,1, 0, 1,  1,  0, 0, 2'b00, 2'b00, 1, 0);
        drv("t4_read_r0_m",     1,   1, 0, 0, 0, 0, 0, 1,  1,  0, 0, 2'b00, 2'b00, 1, 0);
        // flush beats load-use and leaves EX empty
        drv("t5_lw",            1,   1, 1, 2, 6, 1, 1, 0,  0,  0, 0, 2'b00, 2'b00, 1, 0);
        drv("t5_flush",         1,   1, 1, 6, 14,1, 0, 0,  1,  1, 0, 2'b00, 2'b00, 1, 1);
        drv("t5_e_empty",       1,   1, 14,6, 0, 0, 0, 1,  1,  0, 0, 2'b00, 2'b11, 1, 0);
        // hold freezes a stall, async clear during hold
        drv("t6_lw",            1,   1, 1, 2, 7, 1, 1, 0,  0,  0, 0, 2'b00, 2'b00, 1, 0);
        drv("t6_hold1",         1,   1, 7, 3, 15,1, 0, 1,  1,  0, 1, 2'b00, 2'b00, 0, 1);
        drv("t6_hold2",         1,   1, 7, 3, 15,1, 0, 1,  1,  0, 1, 2'b00, 2'b00, 0, 1);
        drv("t6_hold3",         1,   1, 7, 3, 15,1, 0, 1,  1,  0, 1, 2'b00, 2'b00, 0, 1);
        drv("t6_async_clr",     0,   1, 7, 3, 15,1, 0, 1,  1,  0, 1, 2'b00, 2'b00, 1, 0);
        drv("t6_resume",        1,   1, 7, 3, 15,1, 0, 1,  1,  0, 0, 2'b00, 2'b00, 1, 0);
        drv("t6_resume_ex",     1,   1, 15,3, 0, 0, 0, 1,  0,  0, 0, 2'b01, 2'b00, 1, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
